// File: rtl/if_fetch_unit.sv
// Instruction-fetch front end: owns the PC, issues req/gnt/rvalid fetches,
// buffers returned words in order, and redirects or replays on jump/flush.
module if_fetch_unit #(
  parameter int                    ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0,
  parameter int                    DEPTH      = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  jump_en_i,
  input  logic [ADDR_WIDTH-1:0] jump_addr_i,
  input  logic                  pipeline_flush_i,
  output logic                  imem_req_o,
  output logic [ADDR_WIDTH-1:0] imem_addr_o,
  input  logic                  imem_gnt_i,
  input  logic                  imem_rvalid_i,
  input  logic [31:0]           imem_rdata_i,
  output logic                  inst_valid_o,
  input  logic                  inst_ready_i,
  output logic [31:0]           inst_o,
  output logic [ADDR_WIDTH-1:0] inst_addr_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  // Stale responses can outlive several redirects, so give the in-flight
  // counters headroom beyond DEPTH.
  localparam int OUT_W = CNT_W + 4;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] addr;
    logic [31:0]           data;
    logic                  data_ok;
  } entry_t;

  entry_t                q [DEPTH];
  logic [ADDR_WIDTH-1:0] pc;
  logic [PTR_W-1:0]      head;
  logic [PTR_W-1:0]      tail;
  logic [PTR_W-1:0]      fill_ptr;
  logic [CNT_W-1:0]      alloc_count;
  logic [OUT_W-1:0]      outstanding;
  logic [OUT_W-1:0]      discard_cnt;

  logic redirect;
  logic alloc;
  logic rvalid_ok;
  logic drop;
  logic fill;
  logic pop;

  assign redirect     = jump_en_i | pipeline_flush_i;
  assign imem_req_o   = rst_n & (alloc_count < CNT_W'(DEPTH)) & ~redirect;
  assign imem_addr_o  = pc;
  assign alloc        = imem_req_o & imem_gnt_i;
  // A response with nothing in flight is a protocol error and is ignored.
  assign rvalid_ok    = imem_rvalid_i & (outstanding != '0);
  assign drop         = rvalid_ok & (discard_cnt != '0);
  assign fill         = rvalid_ok & (discard_cnt == '0);
  assign inst_valid_o = q[head].data_ok & ~redirect;
  assign pop          = inst_valid_o & inst_ready_i;
  assign inst_o       = q[head].data;
  assign inst_addr_o  = q[head].addr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc          <= RESET_PC;
      head        <= '0;
      tail        <= '0;
      fill_ptr    <= '0;
      alloc_count <= '0;
      outstanding <= '0;
      discard_cnt <= '0;
      // NOTE: the queue storage is reset because inst_o/inst_addr_o are read
      // straight from the head entry and must show zero out of reset.
      for (int i = 0; i < DEPTH; i++) q[i] <= '0;
    end else begin
      // NOTE: all state here uses non-blocking assignments so every read below
      // sees the pre-edge value, matching the combinational decode above.
      outstanding <= outstanding + OUT_W'(alloc) - OUT_W'(rvalid_ok);
      if (redirect) begin
        if (jump_en_i)
          pc <= {jump_addr_i[ADDR_WIDTH-1:2], 2'b00};
        else if (alloc_count != '0)
          pc <= q[head].addr;
        head        <= '0;
        tail        <= '0;
        fill_ptr    <= '0;
        alloc_count <= '0;
        discard_cnt <= outstanding - OUT_W'(rvalid_ok);
        for (int i = 0; i < DEPTH; i++) q[i].data_ok <= 1'b0;
      end else begin
        if (alloc) begin
          q[tail].addr    <= pc;
          q[tail].data_ok <= 1'b0;
          tail            <= tail + 1'b1;
          pc              <= pc + ADDR_WIDTH'(4);
        end
        if (fill) begin
          q[fill_ptr].data    <= imem_rdata_i;
          q[fill_ptr].data_ok <= 1'b1;
          fill_ptr            <= fill_ptr + 1'b1;
        end
        // Popped slot loses data_ok so an empty queue never reads as valid.
        if (pop) begin
          q[head].data_ok <= 1'b0;
          head            <= head + 1'b1;
        end
        if (drop) discard_cnt <= discard_cnt - 1'b1;
        alloc_count <= alloc_count + CNT_W'(alloc) - CNT_W'(pop);
      end
    end
  end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed bench for if_fetch_unit: per-cycle vector table against a small
// in-order memory responder, plus hand-written reset-mid-burst sequence.
module tb_if_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        jump_en_i;
  logic [31:0] jump_addr_i;
  logic        pipeline_flush_i;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_gnt_i;
  logic        imem_rvalid_i;
  logic [31:0] imem_rdata_i;
  logic        inst_valid_o;
  logic        inst_ready_i;
  logic [31:0] inst_o;
  logic [31:0] inst_addr_o;

  if_fetch_unit #(.ADDR_WIDTH(32), .RESET_PC(32'h0), .DEPTH(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .jump_en_i(jump_en_i), .jump_addr_i(jump_addr_i),
    .pipeline_flush_i(pipeline_flush_i),
    .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o),
    .imem_gnt_i(imem_gnt_i), .imem_rvalid_i(imem_rvalid_i),
    .imem_rdata_i(imem_rdata_i),
    .inst_valid_o(inst_valid_o), .inst_ready_i(inst_ready_i),
    .inst_o(inst_o), .inst_addr_o(inst_addr_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        gnt, ready, jump, flush, rv;
    logic [31:0] jaddr;
    logic        req;
    logic [31:0] addr;
    logic        valid;
    logic [31:0] iaddr;
  } vec_t;

  vec_t        vecs[$];
  logic [31:0] pend_q[$];
  int          n_tests = 0;
  int          n_fail  = 0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hC0DE_0000 ^ {a[15:0], a[31:16]};
  endfunction

  function automatic vec_t mk(input logic g, r, j, f, rv, input logic [31:0] ja,
                              input logic req, input logic [31:0] a,
                              input logic v, input logic [31:0] ia);
    vec_t t;
    t.gnt = g; t.ready = r; t.jump = j; t.flush = f; t.rv = rv; t.jaddr = ja;
    t.req = req; t.addr = a; t.valid = v; t.iaddr = ia;
    return t;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Apply inputs just after a rising edge; memory answers the oldest grant if rv.
  task automatic drive(input logic g, r, j, f, rv, input logic [31:0] ja);
    imem_gnt_i       = g;
    inst_ready_i     = r;
    jump_en_i        = j;
    pipeline_flush_i = f;
    jump_addr_i      = ja;
    imem_rvalid_i    = 1'b0;
    imem_rdata_i     = '0;
    if (rv && pend_q.size() != 0) begin
      imem_rvalid_i = 1'b1;
      imem_rdata_i  = mem_word(pend_q.pop_front());
    end
  endtask

  task automatic advance();
    if (imem_req_o && imem_gnt_i) pend_q.push_back(imem_addr_o);
    @(posedge clk);
    #1;
  endtask

  task automatic check_outs(input string tag, input logic req, input logic [31:0] a,
                            input logic v, input logic [31:0] ia);
    check({tag, " req"}, 32'(imem_req_o), 32'(req));
    check({tag, " addr"}, imem_addr_o, a);
    check({tag, " valid"}, 32'(inst_valid_o), 32'(v));
    if (v) begin
      check({tag, " iaddr"}, inst_addr_o, ia);
      check({tag, " inst"}, inst_o, mem_word(ia));
    end
  endtask

  initial begin
    // gnt ready jump flush rv jaddr | req addr valid iaddr
    vecs.push_back(mk(1,1,0,0,1,0, 1,32'h00,0,0));          // first req after release
    vecs.push_back(mk(1,1,0,0,1,0, 1,32'h04,0,0));
    vecs.push_back(mk(1,1,0,0,1,0, 0,32'h08,1,32'h00));      // valid two cycles after gnt
    vecs.push_back(mk(1,1,0,0,1,0, 1,32'h08,1,32'h04));
    vecs.push_back(mk(1,1,0,0,1,0, 1,32'h0C,0,0));
    vecs.push_back(mk(1,1,0,0,1,0, 0,32'h10,1,32'h08));
    vecs.push_back(mk(1,1,0,0,1,0, 1,32'h10,1,32'h0C));
    vecs.push_back(mk(1,0,0,0,1,0, 1,32'h14,0,0));           // decode stalls
    vecs.push_back(mk(1,0,0,0,1,0, 0,32'h18,1,32'h10));      // both slots allocated
    vecs.push_back(mk(1,0,0,0,1,0, 0,32'h18,1,32'h10));
    vecs.push_back(mk(1,0,0,0,1,0, 0,32'h18,1,32'h10));
    vecs.push_back(mk(1,1,0,0,1,0, 0,32'h18,1,32'h10));
    vecs.push_back(mk(1,1,0,0,1,0, 1,32'h18,1,32'h14));      // fetch resumes at 0x18
    vecs.push_back(mk(0,1,0,0,1,0, 1,32'h1C,0,0));           // gnt withheld
    vecs.push_back(mk(0,1,0,0,1,0, 1,32'h1C,1,32'h18));
    vecs.push_back(mk(0,1,0,0,1,0, 1,32'h1C,0,0));
    vecs.push_back(mk(1,1,0,0,1,0, 1,32'h1C,0,0));
    vecs.push_back(mk(1,1,0,0,1,0, 1,32'h20,0,0));
    vecs.push_back(mk(1,1,0,0,0,0, 0,32'h24,1,32'h1C));      // memory holds responses
    vecs.push_back(mk(1,1,0,0,0,0, 1,32'h24,0,0));           // two in flight
    vecs.push_back(mk(1,1,1,0,1,32'h102, 0,32'h28,0,0));     // jump, stale rvalid same cycle
    vecs.push_back(mk(1,1,0,0,1,0, 1,32'h100,0,0));          // second stale dropped
    vecs.push_back(mk(1,1,0,0,1,0, 1,32'h104,0,0));
    vecs.push_back(mk(1,1,0,0,1,0, 0,32'h108,1,32'h100));
    vecs.push_back(mk(1,1,0,0,1,0, 1,32'h108,1,32'h104));
    vecs.push_back(mk(1,1,1,0,0,32'h20, 0,32'h10C,0,0));     // set up flush scenario
    vecs.push_back(mk(1,0,0,0,1,0, 1,32'h20,0,0));
    vecs.push_back(mk(1,0,0,0,1,0, 1,32'h24,0,0));
    vecs.push_back(mk(1,1,0,1,0,0, 0,32'h28,0,0));           // flush kills buffered 0x20
    vecs.push_back(mk(1,1,0,0,1,0, 1,32'h20,0,0));           // replay from 0x20
    vecs.push_back(mk(1,1,0,0,1,0, 1,32'h24,0,0));
    vecs.push_back(mk(1,1,0,0,1,0, 0,32'h28,1,32'h20));
    vecs.push_back(mk(1,1,0,0,1,0, 1,32'h28,1,32'h24));
    vecs.push_back(mk(1,1,1,0,0,32'hFFFF_FFFE, 0,32'h2C,0,0));
    vecs.push_back(mk(1,1,0,0,1,0, 1,32'hFFFF_FFFC,0,0));
    vecs.push_back(mk(1,1,0,0,1,0, 1,32'h00,0,0));           // PC wraps
    vecs.push_back(mk(1,1,0,0,1,0, 0,32'h04,1,32'hFFFF_FFFC));
    vecs.push_back(mk(1,1,0,0,1,0, 1,32'h04,1,32'h00));
    vecs.push_back(mk(1,1,0,0,1,0, 1,32'h08,0,0));

    rst_n = 1'b0;
    drive(0, 0, 0, 0, 0, '0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset req", 32'(imem_req_o), 32'h0);
    check("reset addr", imem_addr_o, 32'h0);
    check("reset valid", 32'(inst_valid_o), 32'h0);
    check("reset inst", inst_o, 32'h0);
    check("reset iaddr", inst_addr_o, 32'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      vec_t t;
      t = vecs[i];
      drive(t.gnt, t.ready, t.jump, t.flush, t.rv, t.jaddr);
      @(negedge clk);
      check_outs($sformatf("v%0d", i), t.req, t.addr, t.valid, t.iaddr);
      advance();
    end

    // Reset mid-burst: outputs return to reset values without a clock edge.
    rst_n = 1'b0;
    pend_q.delete();
    imem_rvalid_i = 1'b1;
    imem_rdata_i  = 32'hDEAD_BEEF;
    #1;
    check("midrst req", 32'(imem_req_o), 32'h0);
    check("midrst addr", imem_addr_o, 32'h0);
    check("midrst valid", 32'(inst_valid_o), 32'h0);
    check("midrst inst", inst_o, 32'h0);
    check("midrst iaddr", inst_addr_o, 32'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Spurious rvalids with nothing outstanding must not create an instruction.
    drive(0, 1, 0, 0, 0, '0);
    imem_rvalid_i = 1'b1;
    imem_rdata_i  = 32'hDEAD_BEEF;
    @(negedge clk);
    check_outs("rst0", 1'b1, 32'h0, 1'b0, '0);
    advance();
    drive(1, 1, 0, 0, 0, '0);
    imem_rvalid_i = 1'b1;
    imem_rdata_i  = 32'hDEAD_BEEF;
    @(negedge clk);
    check_outs("rst1", 1'b1, 32'h0, 1'b0, '0);
    advance();
    drive(1, 1, 0, 0, 1, '0);
    @(negedge clk);
    check_outs("rst2", 1'b1, 32'h4, 1'b0, '0);
    advance();
    drive(1, 1, 0, 0, 1, '0);
    @(negedge clk);
    check_outs("rst3", 1'b0, 32'h8, 1'b1, 32'h0);
    advance();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
